// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: a single outstanding
// valid/ready request is serviced against a word-addressed RAM after WAIT_STATES cycles.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit          NO_WAIT  = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]       wait_cnt;
  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic             misaligned;
  logic             out_of_range;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;

  logic             accept;
  logic             access;
  logic             acc_we;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;

  // Offset arithmetic wraps modulo 2^32, so addresses below the base land far out of range.
  assign offset       = req_addr - BASE_ADDR;
  assign misaligned   = (req_addr[1:0] != 2'b00);
  assign out_of_range = (offset >= SPAN);
  assign req_err      = misaligned | out_of_range;
  assign req_idx      = offset[IDX_W+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          access = !req_err && NO_WAIT;
          if (req_err || NO_WAIT) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // With no wait states the access is taken straight from the request pins.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_idx   = req_idx;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = we_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= 4'd0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (accept && !req_err && !NO_WAIT) begin
        wait_cnt <= CNT_LOAD;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (accept && req_err) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b1;
      end else if (access) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= acc_we ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // RAM is deliberately unreset; a reset before the commit edge leaves it untouched.
  always_ff @(posedge clk) begin
    if (access && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
